kernel_mem_scrub_master: RTL and testbench

Avalon-MM master that drives the kernel on-chip memory's s1 slave port. It fills a window of the 20480-word RAM with a deterministic pattern, then reads the window back and compares it. It reports a mismatch count and the first failing address. The block sits beside the Nios core as a bring-up and self-test engine for the memory.

---
 rtl/kernel_mem_scrub_master_if.sv | 22 ++
 rtl/kernel_mem_scrub_master.sv | 125 ++++++++++++
 tb/tb_kernel_mem_scrub_master.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_mem_scrub_master_if.sv
// kernel_mem_scrub_master_if: Avalon-MM bus between the scrub master and the kernel on-chip memory s1 port.
interface kernel_mem_scrub_master_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                clken;
  logic                reset_req;
  modport master (
    output address, byteenable, chipselect, write, writedata, clken, reset_req,
    input  readdata
  );
  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken, reset_req,
    output readdata
  );
endinterface

// File: rtl/kernel_mem_scrub_master.sv
// kernel_mem_scrub_master: fills a memory window with a pattern, reads it back and counts mismatches.
// Define KERNEL_MEM_SCRUB_LFSR_EN for a Galois LFSR pattern instead of the incrementing one.
module kernel_mem_scrub_master #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              check_only,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag,
  kernel_mem_scrub_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, FILL, CHECK, DRAIN, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] base, num, idx, addr_q;
  logic [DATA_W-1:0] seed_q, pat, exp_q, seed_eff, pat_next;
  logic              cmp_v, last;
`ifdef KERNEL_MEM_SCRUB_LFSR_EN
  assign seed_eff = seed == '0 ? DATA_W'(1) : seed;
  assign pat_next = (pat >> 1) ^ (pat[0] ? DATA_W'(32'h80200003) : '0);
`else
  assign seed_eff = seed;
  assign pat_next = pat + 1'b1;
`endif
  assign last           = idx == num - 1'b1;
  assign bus.byteenable = {(DATA_W/8){bus.chipselect}};
  assign bus.clken      = 1'b1;
  assign bus.reset_req  = 1'b0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      base           <= '0;
      num            <= '0;
      idx            <= '0;
      addr_q         <= '0;
      seed_q         <= '0;
      pat            <= '0;
      exp_q          <= '0;
      cmp_v          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      bus.address    <= '0;
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
    end else begin
      // read issued this cycle is compared against readdata next cycle
      cmp_v  <= state == CHECK;
      exp_q  <= pat;
      addr_q <= bus.address;
      if (cmp_v && bus.readdata != exp_q) begin
        err_count <= err_count + 16'(err_count != 16'hFFFF);
        if (!err_flag) begin
          err_flag       <= 1'b1;
          first_err_addr <= addr_q;
        end
      end
      case (state)
        IDLE: if (start) begin
          base           <= base_addr;
          num            <= num_words;
          seed_q         <= seed_eff;
          pat            <= seed_eff;
          idx            <= '0;
          bus.address    <= base_addr;
          busy           <= 1'b1;
          err_count      <= '0;
          err_flag       <= 1'b0;
          first_err_addr <= '0;
          if (num_words == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state          <= check_only ? CHECK : FILL;
            bus.chipselect <= 1'b1;
            bus.write      <= !check_only;
            bus.writedata  <= check_only ? '0 : seed_eff;
          end
        end
        FILL: if (last) begin
          state         <= CHECK;
          idx           <= '0;
          pat           <= seed_q;
          bus.address   <= base;
          bus.write     <= 1'b0;
          bus.writedata <= '0;
        end else begin
          idx           <= idx + 1'b1;
          pat           <= pat_next;
          bus.address   <= bus.address + 1'b1;
          bus.writedata <= pat_next;
        end
        CHECK: if (last) begin
          state          <= DRAIN;
          bus.chipselect <= 1'b0;
        end else begin
          idx         <= idx + 1'b1;
          pat         <= pat_next;
          bus.address <= bus.address + 1'b1;
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_mem_scrub_master.sv
// tb_kernel_mem_scrub_master: randomized runs against a memory model and a spec-level reference model.
// Uses a 17-bit address so a single check_only run can exceed 65535 mismatches and saturate err_count.
module tb_kernel_mem_scrub_master;
  localparam int AW = 17;
  localparam int M  = 1 << AW;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          check_only = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, err_flag;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [31:0]   mem [0:M-1];
  int            tests = 0;
  int            fails = 0;

  kernel_mem_scrub_master_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

  kernel_mem_scrub_master #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .check_only(check_only),
    .base_addr(base_addr), .num_words(num_words), .seed(seed),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .err_flag(err_flag), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.chipselect && bus.write) mem[bus.address] <= bus.writedata;
    bus.readdata <= (bus.chipselect && !bus.write) ? mem[bus.address] : 32'h0;
  end

  function automatic logic [31:0] nxt(input logic [31:0] p);
`ifdef KERNEL_MEM_SCRUB_LFSR_EN
    return (p >> 1) ^ (p[0] ? 32'h80200003 : 32'h0);
`else
    return p + 32'd1;
`endif
  endfunction

  function automatic logic [31:0] fix_seed(input logic [31:0] s);
`ifdef KERNEL_MEM_SCRUB_LFSR_EN
    return s == 32'h0 ? 32'h1 : s;
`else
    return s;
`endif
  endfunction

  task automatic preload(input logic [AW-1:0] b, input int n, input logic [31:0] s, input bit inv);
    logic [31:0] p;
    p = fix_seed(s);
    for (int i = 0; i < n; i++) begin
      mem[AW'(b + i)] = inv ? ~p : p;
      p = nxt(p);
    end
  endtask

  task automatic run(input bit co, input logic [AW-1:0] b, input logic [AW-1:0] n,
                     input logic [31:0] s, input bit poke);
    int            f, dc, exp_err, bad, dones;
    bit            ef, ecs, ewr;
    logic [AW-1:0] exp_first, ea;
    logic [31:0]   pf, pc, ewd;
    exp_err = 0; ef = 1'b0; exp_first = '0;
    if (co) begin
      pc = fix_seed(s);
      for (int i = 0; i < int'(n); i++) begin
        if (mem[AW'(b + i)] !== pc) begin
          if (!ef) begin ef = 1'b1; exp_first = AW'(b + i); end
          if (exp_err < 65535) exp_err++;
        end
        pc = nxt(pc);
      end
    end
    f  = co ? 0 : int'(n);
    dc = n == '0 ? 1 : f + int'(n) + 2;
    @(negedge clk);
    check_only = co; base_addr = b; num_words = n; seed = s; start = 1'b1;
    bad = 0; dones = 0; pf = fix_seed(s);
    for (int c = 1; c <= dc + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      ea = '0; ewd = 32'h0;
      if (n != '0 && c <= f) begin
        ecs = 1'b1; ewr = 1'b1; ea = AW'(b + c - 1); ewd = pf; pf = nxt(pf);
      end else if (n != '0 && c <= f + int'(n)) begin
        ecs = 1'b1; ewr = 1'b0; ea = AW'(b + c - f - 1);
      end else begin
        ecs = 1'b0; ewr = 1'b0;
      end
      if (bus.chipselect !== ecs || bus.write !== ewr || bus.writedata !== ewd ||
          bus.byteenable !== {4{ecs}} || (ecs && bus.address !== ea)) bad++;
      if (done !== (c == dc) || busy !== (c <= dc)) bad++;
      if (done === 1'b1) dones++;
      if (poke) start = (c == 1 || c == dc);
    end
    start = 1'b0;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bus_timing n=%0d co=%0d: %0d bad cycles, required 0", n, co, bad); end
    tests++;
    if (dones !== 1) begin fails++; $display("FAIL done_pulses: got %0d, required 1", dones); end
    tests++;
    if (err_count !== 16'(exp_err)) begin fails++; $display("FAIL err_count: got %0d, required %0d", err_count, exp_err); end
    tests++;
    if (err_flag !== ef) begin fails++; $display("FAIL err_flag: got %0b, required %0b", err_flag, ef); end
    tests++;
    if (first_err_addr !== exp_first) begin fails++; $display("FAIL first_err_addr: got %0d, required %0d", first_err_addr, exp_first); end
    if (!co) begin
      pc = fix_seed(s); bad = 0;
      for (int i = 0; i < int'(n); i++) begin
        if (mem[AW'(b + i)] !== pc) bad++;
        pc = nxt(pc);
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL fill_contents: %0d wrong words, required 0", bad); end
    end
  endtask

  task automatic test_reset;
    start = 1'b1; num_words = 17'd4;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, err_count, first_err_addr, err_flag, bus.address, bus.byteenable,
         bus.chipselect, bus.write, bus.writedata, bus.reset_req} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero (busy=%0b cs=%0b wr=%0b)", busy, bus.chipselect, bus.write);
    end
    tests++;
    if (bus.clken !== 1'b1) begin fails++; $display("FAIL reset_clken: got %0b, required 1", bus.clken); end
    start = 1'b0; reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run(1'b0, 17'd0, 17'd4, 32'h100, 1'b0);
  endtask

  task automatic test_check_only;
    preload(17'd16, 8, 32'h0, 1'b0);
    mem[19] = ~mem[19];
    run(1'b1, 17'd16, 17'd8, 32'h0, 1'b0);
    tests++;
    if (first_err_addr !== 17'd19 || err_count !== 16'd1) begin
      fails++; $display("FAIL check_only_word19: addr %0d count %0d, required 19 and 1", first_err_addr, err_count);
    end
  endtask

  task automatic test_zero;
    run(1'b0, 17'd50, 17'd0, 32'h1234, 1'b0);
  endtask

  task automatic test_back_to_back;
    run(1'b0, 17'd200, 17'd6, 32'hFFFF_FFFE, 1'b1);
    run(1'b1, 17'd300, 17'd5, 32'h55, 1'b1);
    run(1'b0, 17'd7, 17'd0, 32'h9, 1'b1);
  endtask

  task automatic test_random;
    bit co; int n; logic [AW-1:0] b; logic [31:0] s;
    for (int k = 0; k < 6; k++) begin
      co = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 40);
      b  = AW'($urandom_range(M - 60, M - 1));
      s  = $urandom;
      if (co) begin
        preload(b, n, s, 1'b0);
        for (int j = 0; j < int'($urandom_range(0, 3)); j++)
          mem[AW'(b + $urandom_range(0, n - 1))] ^= 32'h1 << $urandom_range(0, 31);
      end
      run(co, b, AW'(n), s, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    check_only = 1'b0; base_addr = 17'd1000; num_words = 17'd20; seed = 32'h7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (bus.chipselect !== 1'b0 || bus.write !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL async_reset: cs=%0b wr=%0b busy=%0b, required 0", bus.chipselect, bus.write, busy);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef KERNEL_MEM_SCRUB_LFSR_EN
  task automatic test_lfsr;
    run(1'b0, 17'd400, 17'd2, 32'h0, 1'b0);
    tests++;
    if (mem[400] !== 32'h1 || mem[401] !== 32'h80200003) begin
      fails++; $display("FAIL lfsr_seed0: got %h %h, required 00000001 80200003", mem[400], mem[401]);
    end
  endtask
`endif

  task automatic test_saturate;
    preload(AW'(M - 1000), 65600, 32'h5A5A0000, 1'b1);
    run(1'b1, AW'(M - 1000), 17'd65600, 32'h5A5A0000, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < M; i++) mem[i] = 32'h0;
    test_reset;
    test_basic;
    test_check_only;
    test_zero;
    test_back_to_back;
    test_random;
    test_async_reset;
`ifdef KERNEL_MEM_SCRUB_LFSR_EN
    test_lfsr;
`endif
    test_saturate;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
